// File: rtl/blink_seq_pkg.sv
// Shared types and default widths for the blink pattern sequencer.
package blink_seq_pkg;

    localparam int DEF_NUM_STEPS = 4;
    localparam int DEF_SPEED_W   = 28;
    localparam int DEF_LED_W     = 4;
    localparam int DEF_DWELL_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } blink_seq_state_e;

    typedef struct packed {
        logic [DEF_SPEED_W-1:0] speed;
        logic [DEF_LED_W-1:0]   mask;
        logic [DEF_DWELL_W-1:0] dwell;
    } blink_step_t;

endpackage

// File: rtl/blink_tick_gen.sv
// Period counter: emits a one-cycle tick every max(speed,1) cycles while
// clear is low. Holding clear high parks the counter at zero.
module blink_tick_gen
    import blink_seq_pkg::*;
#(
    parameter int SPEED_W = DEF_SPEED_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [SPEED_W-1:0] speed,
    output logic               tick
);

    logic [SPEED_W-1:0] cnt;
    logic [SPEED_W-1:0] last_cnt;

    // Terminal count is effective speed minus one; speed 0 behaves as 1.
    always_comb begin
        last_cnt = (speed == '0) ? '0 : speed - SPEED_W'(1);
        tick     = !clear && (cnt == last_cnt);
    end

    // Free-running count that restarts on every tick or clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + SPEED_W'(1);
        end
    end

endmodule

// File: rtl/blink_sequencer.sv
// Pattern sequencer driving led_controller speed and LED gate mask.
// Define BLINK_SEQ_LOOP_EN to replay the table continuously; otherwise the
// sequence plays once and returns to IDLE.
module blink_sequencer
    import blink_seq_pkg::*;
#(
    parameter int NUM_STEPS = DEF_NUM_STEPS,
    parameter int SPEED_W   = DEF_SPEED_W,
    parameter int LED_W     = DEF_LED_W,
    parameter int DWELL_W   = DEF_DWELL_W,
    localparam int IDX_W    = $clog2(NUM_STEPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [SPEED_W-1:0] cfg_speed,
    input  logic [LED_W-1:0]   cfg_mask,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic               cfg_ready,
    output logic [SPEED_W-1:0] speed_sel,
    output logic [LED_W-1:0]   led_en,
    output logic               busy,
    output logic [IDX_W-1:0]   step_idx,
    output logic               wrap
);

    logic [SPEED_W-1:0] tbl_speed [NUM_STEPS];
    logic [LED_W-1:0]   tbl_mask  [NUM_STEPS];
    logic [DWELL_W-1:0] tbl_dwell [NUM_STEPS];

    blink_seq_state_e   state, state_nxt;
    logic [DWELL_W-1:0] cur_dwell, dwell_cnt, dwell_last;
    logic               tick, step_end, last_step;

    blink_tick_gen #(.SPEED_W(SPEED_W)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state != RUN),
        .speed (speed_sel),
        .tick  (tick)
    );

    // Step-end detection: last period of the effective dwell.
    always_comb begin
        dwell_last = (cur_dwell == '0) ? '0 : cur_dwell - DWELL_W'(1);
        step_end   = (state == RUN) && tick && (dwell_cnt == dwell_last);
        last_step  = (step_idx == IDX_W'(NUM_STEPS - 1));
        busy       = (state != IDLE);
    end

    // Next-state and wrap pulse; stop overrides everything, including wrap.
    always_comb begin
        state_nxt = state;
        wrap      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = RUN;
            RUN: begin
                if (step_end) begin
                    if (last_step) begin
                        wrap = 1'b1;
`ifdef BLINK_SEQ_LOOP_EN
                        state_nxt = LOAD;
`else
                        state_nxt = IDLE;
`endif
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (stop) begin
            state_nxt = IDLE;
            wrap      = 1'b0;
        end
    end

    // State register and registered table-ready flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            cfg_ready <= (state_nxt == IDLE);
        end
    end

    // Pattern table; writes accepted only while idle, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                tbl_speed[i] <= '0;
                tbl_mask[i]  <= '0;
                tbl_dwell[i] <= '0;
            end
        end else if (cfg_we && cfg_ready) begin
            tbl_speed[cfg_addr] <= cfg_speed;
            tbl_mask[cfg_addr]  <= cfg_mask;
            tbl_dwell[cfg_addr] <= cfg_dwell;
        end
    end

    // Step index: reset on playback start, advance or wrap at step end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_idx <= '0;
        end else if (state == IDLE && state_nxt == LOAD) begin
            step_idx <= '0;
        end else if (step_end && !stop) begin
            step_idx <= last_step ? '0 : step_idx + IDX_W'(1);
        end
    end

    // Output/entry registers loaded in LOAD; LED gate forced off in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            speed_sel <= '0;
            led_en    <= '0;
            cur_dwell <= '0;
        end else begin
            if (state == LOAD) begin
                speed_sel <= tbl_speed[step_idx];
                cur_dwell <= tbl_dwell[step_idx];
            end
            if (state_nxt == IDLE) begin
                led_en <= '0;
            end else if (state == LOAD) begin
                led_en <= tbl_mask[step_idx];
            end
        end
    end

    // Dwell counter: periods completed within the current step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_cnt <= '0;
        end else if (state != RUN || step_end) begin
            dwell_cnt <= '0;
        end else if (tick) begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
        end
    end

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed testbench for blink_sequencer (default one-shot build, or the
// looping build when BLINK_SEQ_LOOP_EN is defined).
module tb_blink_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [27:0] cfg_speed = '0;
    logic [3:0]  cfg_mask = '0;
    logic [7:0]  cfg_dwell = '0;
    logic        cfg_ready;
    logic [27:0] speed_sel;
    logic [3:0]  led_en;
    logic        busy;
    logic [1:0]  step_idx;
    logic        wrap;

    int n_checks = 0;
    int n_fail   = 0;

    int         dur [4];
    logic [3:0] msk [4];
    logic [27:0] spd [4];
    int         wraps;
    logic       busy_after;
    logic [1:0] idx_after;
    logic [3:0] led_after;

    blink_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_speed (cfg_speed),
        .cfg_mask  (cfg_mask),
        .cfg_dwell (cfg_dwell),
        .cfg_ready (cfg_ready),
        .speed_sel (speed_sel),
        .led_en    (led_en),
        .busy      (busy),
        .step_idx  (step_idx),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [27:0] s,
                               input logic [3:0] m, input logic [7:0] d);
        cfg_addr = a; cfg_speed = s; cfg_mask = m; cfg_dwell = d;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic program_default();
        write_entry(2'd0, 28'd4, 4'b0001, 8'd2);
        write_entry(2'd1, 28'd2, 4'b0010, 8'd3);
        write_entry(2'd2, 28'd1, 4'b0100, 8'd1);
        write_entry(2'd3, 28'd3, 4'b1000, 8'd1);
    endtask

    // Pulse start, then sample n cycles recording per-step duration, the
    // mask/speed seen on the step's second cycle and wrap pulses.
    task automatic play(input int n, input bit do_stop, input bit poke);
        for (int k = 0; k < 4; k++) begin
            dur[k] = 0; msk[k] = 4'bxxxx; spd[k] = 'x;
        end
        wraps = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            if (poke && i == 1) begin
                cfg_addr = 2'd1; cfg_mask = 4'b1111; cfg_speed = 28'd1; cfg_dwell = 8'd1;
                cfg_we = 1'b1;
            end else begin
                cfg_we = 1'b0;
            end
            if (busy) begin
                if (dur[step_idx] == 1) begin
                    msk[step_idx] = led_en;
                    spd[step_idx] = speed_sel;
                end
                dur[step_idx]++;
            end
            if (wrap) wraps++;
        end
        cfg_we = 1'b0;
        tick();
        busy_after = busy; idx_after = step_idx; led_after = led_en;
        if (do_stop) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_checks++; if (speed_sel !== 28'd0) begin n_fail++; $display("FAIL reset_speed_sel: got %0d want 0", speed_sel); end
        n_checks++; if (led_en !== 4'd0) begin n_fail++; $display("FAIL reset_led_en: got %b want 0000", led_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (step_idx !== 2'd0) begin n_fail++; $display("FAIL reset_step_idx: got %0d want 0", step_idx); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_sequence();
        program_default();
`ifdef BLINK_SEQ_LOOP_EN
        play(22, 1'b0, 1'b0);
`else
        play(22, 1'b1, 1'b0);
`endif
        n_checks++; if (dur[0] !== 9) begin n_fail++; $display("FAIL seq_dur0: got %0d want 9", dur[0]); end
        n_checks++; if (dur[1] !== 7) begin n_fail++; $display("FAIL seq_dur1: got %0d want 7", dur[1]); end
        n_checks++; if (dur[2] !== 2) begin n_fail++; $display("FAIL seq_dur2: got %0d want 2", dur[2]); end
        n_checks++; if (dur[3] !== 4) begin n_fail++; $display("FAIL seq_dur3: got %0d want 4", dur[3]); end
        n_checks++; if (msk[0] !== 4'b0001) begin n_fail++; $display("FAIL seq_mask0: got %b want 0001", msk[0]); end
        n_checks++; if (msk[1] !== 4'b0010) begin n_fail++; $display("FAIL seq_mask1: got %b want 0010", msk[1]); end
        n_checks++; if (msk[2] !== 4'b0100) begin n_fail++; $display("FAIL seq_mask2: got %b want 0100", msk[2]); end
        n_checks++; if (msk[3] !== 4'b1000) begin n_fail++; $display("FAIL seq_mask3: got %b want 1000", msk[3]); end
        n_checks++; if (spd[0] !== 28'd4) begin n_fail++; $display("FAIL seq_speed0: got %0d want 4", spd[0]); end
        n_checks++; if (spd[3] !== 28'd3) begin n_fail++; $display("FAIL seq_speed3: got %0d want 3", spd[3]); end
        n_checks++; if (wraps !== 1) begin n_fail++; $display("FAIL seq_wraps: got %0d want 1", wraps); end
        n_checks++; if (idx_after !== 2'd0) begin n_fail++; $display("FAIL seq_idx_after: got %0d want 0", idx_after); end
`ifdef BLINK_SEQ_LOOP_EN
        n_checks++; if (busy_after !== 1'b1) begin n_fail++; $display("FAIL loop_busy_after: got %b want 1", busy_after); end
        begin
            int w2;
            int wpos;
            w2 = 0; wpos = -1;
            for (int j = 0; j < 22; j++) begin
                if (j > 0) tick();
                if (j == 9) begin
                    n_checks++; if (step_idx !== 2'd1) begin n_fail++; $display("FAIL loop_second_pass_idx: got %0d want 1", step_idx); end
                end
                if (wrap) begin w2++; wpos = j; end
            end
            n_checks++; if (w2 !== 1) begin n_fail++; $display("FAIL loop_wraps2: got %0d want 1", w2); end
            n_checks++; if (wpos !== 21) begin n_fail++; $display("FAIL loop_wrap_pos: got %0d want 21", wpos); end
            stop = 1'b1; tick(); stop = 1'b0;
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL loop_stop_busy: got %b want 0", busy); end
        end
`else
        n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL seq_busy_after: got %b want 0", busy_after); end
        n_checks++; if (led_after !== 4'b0) begin n_fail++; $display("FAIL seq_led_after: got %b want 0000", led_after); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL seq_cfg_ready: got %b want 1", cfg_ready); end
`endif
    endtask

    task automatic test_reset_midrun();
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrun_pre_busy: got %b want 1", busy); end
        #3;
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrun_busy: got %b want 0", busy); end
        n_checks++; if (led_en !== 4'b0) begin n_fail++; $display("FAIL midrun_led_en: got %b want 0000", led_en); end
        n_checks++; if (speed_sel !== 28'd0) begin n_fail++; $display("FAIL midrun_speed_sel: got %0d want 0", speed_sel); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL midrun_cfg_ready: got %b want 1", cfg_ready); end
        n_checks++; if (step_idx !== 2'd0) begin n_fail++; $display("FAIL midrun_step_idx: got %0d want 0", step_idx); end
        #2;
        rst = 1'b1;
        tick();
        // Cleared table: every entry is speed 0 / dwell 0 / mask 0.
        play(8, 1'b1, 1'b0);
        n_checks++; if (msk[0] !== 4'b0) begin n_fail++; $display("FAIL cleared_mask0: got %b want 0000", msk[0]); end
        n_checks++; if (dur[0] !== 2) begin n_fail++; $display("FAIL zero_entry_dur0: got %0d want 2", dur[0]); end
        n_checks++; if (dur[3] !== 2) begin n_fail++; $display("FAIL zero_entry_dur3: got %0d want 2", dur[3]); end
    endtask

    task automatic test_busy_write();
        program_default();
        play(22, 1'b1, 1'b1);
        n_checks++; if (msk[1] !== 4'b0010) begin n_fail++; $display("FAIL busy_write_mask1: got %b want 0010", msk[1]); end
        n_checks++; if (dur[1] !== 7) begin n_fail++; $display("FAIL busy_write_dur1: got %0d want 7", dur[1]); end
    endtask

    task automatic test_start_stop();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_stop_busy: got %b want 0", busy); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_stop_busy2: got %b want 0", busy); end
    endtask

    task automatic test_stop_on_step_end();
        int s3;
        int wr;
        bit done;
        s3 = 0; wr = 0; done = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (i > 0) tick();
            if (busy && step_idx == 2'd3) begin
                s3++;
                if (s3 == 4) begin
                    stop = 1'b1;
                    #1;
                    done = 1'b1;
                end
            end
            if (wrap) wr++;
        end
        tick();
        stop = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stop_end_reached: got %b want 1", done); end
        n_checks++; if (wr !== 0) begin n_fail++; $display("FAIL stop_end_wraps: got %0d want 0", wr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_end_busy: got %b want 0", busy); end
        n_checks++; if (led_en !== 4'b0) begin n_fail++; $display("FAIL stop_end_led_en: got %b want 0000", led_en); end
        n_checks++; if (speed_sel !== 28'd3) begin n_fail++; $display("FAIL stop_end_speed_hold: got %0d want 3", speed_sel); end
    endtask

    task automatic test_start_with_write();
        cfg_addr = 2'd0; cfg_speed = 28'd1; cfg_mask = 4'b1010; cfg_dwell = 8'd1;
        cfg_we = 1'b1; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_write_busy: got %b want 1", busy); end
        tick();
        n_checks++; if (led_en !== 4'b1010) begin n_fail++; $display("FAIL start_write_mask: got %b want 1010", led_en); end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_reset_midrun();
        test_busy_write();
        test_start_stop();
        test_stop_on_step_end();
        test_start_with_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
